sumac2_arbitro: RTL and testbench
=================================

Name: sumac2_arbitro

Overview:
- Shares one SumaC2 two's-complement adder (ANCHO bits) among NUM_REQ requesters.
- Each requester presents a, b, ci with a valid/ready handshake.
- A round-robin arbiter picks one request and sequences it through the adder.
- The result is held in registers and returned with the requester ID over a valid/ready response channel.

Parameters:
- ANCHO, 8: operand/result width in bits; must be >= 2.
- NUM_REQ, 4: number of requesters; must be >= 2.
- ID_W, $clog2(NUM_REQ): localparam; requester ID width.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester accept; at most one bit high (one-hot or zero).
- req_a  in  NUM_REQ*ANCHO  packed operand a; requester i uses bits [i*ANCHO +: ANCHO].
- req_b  in  NUM_REQ*ANCHO  packed operand b; same packing as req_a.
- req_ci  in  NUM_REQ  per-requester carry-in.
- rsp_valid  out  1  result valid.
- rsp_ready  in  1  consumer accepts the result.
- rsp_id  out  ID_W  index of the requester that owns the result.
- rsp_s  out  ANCHO  sum a+b+ci, modulo 2^ANCHO.
- rsp_cout  out  1  carry out of the MSB.
- rsp_ovf  out  1  signed overflow flag.
- busy  out  1  high whenever the FSM is not in IDLE.

Behaviour:
- Reset (async assert, sync release):
  - state=IDLE; rr_ptr=NUM_REQ-1, so requester 0 has first priority.
  - Operand registers = 0.
  - rsp_valid=0, rsp_id=0, rsp_s=0, rsp_cout=0, rsp_ovf=0, busy=0, req_ready=0.
- FSM states: IDLE, SUMA, RESP.
- IDLE:
  - If any req_valid is high, the winner is the first set bit scanning from (rr_ptr+1) mod NUM_REQ upward, with wrap-around.
  - req_ready[winner]=1 combinationally in that same cycle.
  - On the clock edge: capture a, b, ci and winner ID; rr_ptr<=winner; go to SUMA.
  - If no request is valid, stay in IDLE; req_ready=0.
- SUMA:
  - The SumaC2 inputs come from the operand registers only.
  - On the edge: rsp_s<=s, rsp_cout<=coutfin, rsp_ovf<=(a[MSB]==b[MSB]) && (s[MSB]!=a[MSB]), rsp_id<=captured ID.
  - rsp_valid<=1; go to RESP. req_ready=0.
- RESP:
  - rsp_* held stable while rsp_valid=1 and rsp_ready=0.
  - On rsp_ready=1: rsp_valid<=0 on the edge; go to IDLE. rsp_s/rsp_cout/rsp_ovf/rsp_id keep their last values.
  - req_ready=0 throughout RESP.
- Latency and throughput:
  - Handshake in cycle T gives rsp_valid=1 from T+2.
  - Minimum 3 cycles per operation, reached when rsp_ready is held high.
- Requester side:
  - Inputs are sampled only on a cycle where req_valid&req_ready.
  - A requester may drop valid without penalty; losing requesters are not acknowledged.
  - Changing req_a/req_b/req_ci after acceptance does not affect the result.
- Fairness: a requester that holds valid is granted within NUM_REQ operations.
- Reset mid-operation: the in-flight operation is discarded, rsp_valid drops immediately (async), and no response is emitted.
- Width rules:
  - Sum is computed modulo 2^ANCHO.
  - ci participates in both cout and ovf.
  - Example: 8'h7F+8'h00+ci=1 gives s=8'h80, ovf=1.

Decomposition:
- Package sumac2_arb_pkg holds:
  - typedef enum logic [1:0] {IDLE, SUMA, RESP} estado_t.
  - A function for the signed-overflow rule.
- Sub-module rr_arbitro (NUM_REQ):
  - Inputs: req vector, enable, rr_ptr.
  - Outputs: one-hot grant and binary ID.
  - Purely combinational; the pointer register stays in the parent.
- Exactly one SumaC2 instance (ANCHO) sits in the parent.

Test Plan:
- Single request, req0 a=8'h0A b=8'h05 ci=0, rsp_ready=1 -> req_ready[0] in the same cycle; 2 cycles later rsp_valid=1, rsp_id=0, rsp_s=8'h0F, cout=0, ovf=0.
- All 4 valid continuously after reset, rsp_ready=1 -> grant order 0,1,2,3,0; one result every 3 cycles with matching rsp_id.
- Carry and overflow:
  - req1 a=8'hFF b=8'h01 ci=1 -> s=8'h01, cout=1, ovf=0.
  - req2 a=8'h7F b=8'h01 ci=0 -> s=8'h80, cout=0, ovf=1.
  - req3 a=8'h80 b=8'h80 ci=0 -> s=8'h00, cout=1, ovf=1.
- Backpressure: rsp_ready=0 for 5 cycles in RESP -> rsp_* stable, busy=1, all req_ready=0; then rsp_ready=1 -> one cycle later IDLE, the next grant is taken.
- Pointer fairness: last grant=2, then req0 and req3 valid together -> req3 granted, then req0.
- rst_n low during SUMA -> rsp_valid=0 and busy=0 immediately; after release req0 wins first; no stale response appears.

Source files
------------

// File: rtl/sumac2_arb_pkg.sv
// Shared types and helpers for the round-robin arbitrated SumaC2 adder.
// Imported by the top level of the slice.
package sumac2_arb_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SUMA = 2'd1,
    RESP = 2'd2
  } estado_t;

  // Two's-complement overflow: operands share a sign that the sum does not.
  function automatic logic ovf_c2(input logic a_msb, input logic b_msb, input logic s_msb);
    return (a_msb == b_msb) && (s_msb != a_msb);
  endfunction

endpackage

// File: rtl/sumac2_arbitro_if.sv
// Request/response bundle between NUM_REQ requesters, one consumer and the
// shared adder. The master side drives requests and accepts responses.
interface sumac2_arbitro_if #(
  parameter int ANCHO   = 8,
  parameter int NUM_REQ = 4
);
  localparam int ID_W = $clog2(NUM_REQ);

  logic [NUM_REQ-1:0]       req_valid;
  logic [NUM_REQ-1:0]       req_ready;
  logic [NUM_REQ*ANCHO-1:0] req_a;
  logic [NUM_REQ*ANCHO-1:0] req_b;
  logic [NUM_REQ-1:0]       req_ci;

  logic                     rsp_valid;
  logic                     rsp_ready;
  logic [ID_W-1:0]          rsp_id;
  logic [ANCHO-1:0]         rsp_s;
  logic                     rsp_cout;
  logic                     rsp_ovf;

  modport master (
    output req_valid, req_a, req_b, req_ci, rsp_ready,
    input  req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf
  );

  modport slave (
    input  req_valid, req_a, req_b, req_ci, rsp_ready,
    output req_ready, rsp_valid, rsp_id, rsp_s, rsp_cout, rsp_ovf
  );

endinterface

// File: rtl/rr_arbitro.sv
// Combinational round-robin picker: first requester after ptr, with wrap.
// The pointer register lives in the parent.
module rr_arbitro #(
  parameter int NUM_REQ = 4,
  parameter int ID_W    = $clog2(NUM_REQ)
) (
  input  logic [NUM_REQ-1:0] req,
  input  logic               en,
  input  logic [ID_W-1:0]    ptr,
  output logic [NUM_REQ-1:0] gnt,
  output logic [ID_W-1:0]    id
);

  int unsigned idx;
  logic        found;

  always_comb begin
    // NOTE: every output of this block is given a default before any branch, so no path can leave a latch.
    gnt   = '0;
    id    = '0;
    idx   = 0;
    found = 1'b0;
    if (en) begin
      for (int k = 1; k <= NUM_REQ; k++) begin
        idx = (int'(ptr) + k) % NUM_REQ;
        if (!found && req[idx]) begin
          found    = 1'b1;
          gnt[idx] = 1'b1;
          id       = ID_W'(idx);
        end
      end
    end
  end

endmodule

// File: rtl/sumac2.sv
// SumaC2: ANCHO-bit ripple-carry two's-complement adder with carry in/out.
// Sum wraps modulo 2^ANCHO; coutfin is the carry out of the MSB.
module sumac2 #(
  parameter int ANCHO = 8
) (
  input  logic [ANCHO-1:0] a,
  input  logic [ANCHO-1:0] b,
  input  logic             ci,
  output logic [ANCHO-1:0] s,
  output logic             coutfin
);

  logic carry;

  always_comb begin
    carry = ci;
    s     = '0;
    for (int i = 0; i < ANCHO; i++) begin
      s[i]  = a[i] ^ b[i] ^ carry;
      carry = (a[i] & b[i]) | (carry & (a[i] ^ b[i]));
    end
    coutfin = carry;
  end

endmodule

// File: rtl/sumac2_arbitro.sv
// One SumaC2 adder shared by NUM_REQ requesters: round-robin grant, one
// registered add, result returned with the owner ID on a valid/ready channel.
module sumac2_arbitro
  import sumac2_arb_pkg::*;
#(
  parameter int ANCHO   = 8,
  parameter int NUM_REQ = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  sumac2_arbitro_if.slave      bus,
  output logic                 busy
);

  localparam int ID_W = $clog2(NUM_REQ);

  estado_t             estado, estado_sig;
  logic [ID_W-1:0]     rr_ptr;
  logic [NUM_REQ-1:0]  gnt;
  logic [ID_W-1:0]     win_id;
  logic                arb_en;
  logic                acepta;

  logic [ANCHO-1:0]    op_a, op_b;
  logic                op_ci;
  logic [ID_W-1:0]     op_id;

  logic [ANCHO-1:0]    sum_s;
  logic                sum_cout;

  logic                rsp_valid_q;
  logic [ID_W-1:0]     rsp_id_q;
  logic [ANCHO-1:0]    rsp_s_q;
  logic                rsp_cout_q;
  logic                rsp_ovf_q;

  // Grants are only offered in IDLE and never while reset is held.
  assign arb_en = (estado == IDLE) && rst_n;
  assign acepta = |gnt;

  rr_arbitro #(
    .NUM_REQ (NUM_REQ),
    .ID_W    (ID_W)
  ) u_arb (
    .req (bus.req_valid),
    .en  (arb_en),
    .ptr (rr_ptr),
    .gnt (gnt),
    .id  (win_id)
  );

  sumac2 #(
    .ANCHO (ANCHO)
  ) u_suma (
    .a       (op_a),
    .b       (op_b),
    .ci      (op_ci),
    .s       (sum_s),
    .coutfin (sum_cout)
  );

  always_comb begin
    estado_sig = estado;
    unique case (estado)
      IDLE:    if (acepta) estado_sig = SUMA;
      SUMA:    estado_sig = RESP;
      RESP:    if (bus.rsp_ready) estado_sig = IDLE;
      default: estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: state registers use non-blocking assignment so every flop samples pre-edge values.
    if (!rst_n) estado <= IDLE;
    else        estado <= estado_sig;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: operand and result registers are reset too, so nothing stale is observable after reset.
    if (!rst_n) begin
      rr_ptr      <= ID_W'(NUM_REQ - 1);
      op_a        <= '0;
      op_b        <= '0;
      op_ci       <= 1'b0;
      op_id       <= '0;
      rsp_valid_q <= 1'b0;
      rsp_id_q    <= '0;
      rsp_s_q     <= '0;
      rsp_cout_q  <= 1'b0;
      rsp_ovf_q   <= 1'b0;
    end else begin
      unique case (estado)
        IDLE: begin
          if (acepta) begin
            op_a   <= bus.req_a[int'(win_id)*ANCHO +: ANCHO];
            op_b   <= bus.req_b[int'(win_id)*ANCHO +: ANCHO];
            op_ci  <= bus.req_ci[win_id];
            op_id  <= win_id;
            rr_ptr <= win_id;
          end
        end
        SUMA: begin
          rsp_s_q     <= sum_s;
          rsp_cout_q  <= sum_cout;
          rsp_ovf_q   <= ovf_c2(op_a[ANCHO-1], op_b[ANCHO-1], sum_s[ANCHO-1]);
          rsp_id_q    <= op_id;
          rsp_valid_q <= 1'b1;
        end
        RESP: begin
          if (bus.rsp_ready) rsp_valid_q <= 1'b0;
        end
        default: rsp_valid_q <= 1'b0;
      endcase
    end
  end

  assign bus.req_ready = gnt;
  assign bus.rsp_valid = rsp_valid_q;
  assign bus.rsp_id    = rsp_id_q;
  assign bus.rsp_s     = rsp_s_q;
  assign bus.rsp_cout  = rsp_cout_q;
  assign bus.rsp_ovf   = rsp_ovf_q;
  assign busy          = (estado != IDLE);

endmodule

// File: tb/tb_sumac2_arbitro.sv
// Self-checking bench for sumac2_arbitro: vector table, scoreboard queue and
// hand-written sequences for latency, backpressure, fairness and reset.
module tb_sumac2_arbitro;

  localparam int ANCHO   = 8;
  localparam int NUM_REQ = 4;
  localparam int ID_W    = 2;

  typedef struct packed {
    logic [ID_W-1:0]  id;
    logic [ANCHO-1:0] s;
    logic             cout;
    logic             ovf;
  } rsp_t;

  typedef struct {
    int               req;
    logic [ANCHO-1:0] a;
    logic [ANCHO-1:0] b;
    logic             ci;
    rsp_t             exp;
  } vec_t;

  logic clk = 1'b0;
  logic rst_n;
  logic busy;

  rsp_t exp_q[$];
  int   n_cmp  = 0;
  int   n_fail = 0;

  always #5 clk = ~clk;

  sumac2_arbitro_if #(.ANCHO(ANCHO), .NUM_REQ(NUM_REQ)) bus ();

  sumac2_arbitro #(.ANCHO(ANCHO), .NUM_REQ(NUM_REQ)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus),
    .busy  (busy)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    n_cmp++;
    if (act !== req) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, req);
    end
  endtask

  // Independent reference: signed range test for overflow, wide add for carry.
  function automatic rsp_t model(input int id, input logic [7:0] a, input logic [7:0] b, input logic ci);
    rsp_t r;
    int   ws, ss;
    ws     = int'(a) + int'(b) + int'(ci);
    ss     = int'($signed(a)) + int'($signed(b)) + int'(ci);
    r.id   = ID_W'(id);
    r.s    = ws[7:0];
    r.cout = ws > 255;
    r.ovf  = (ss > 127) || (ss < -128);
    return r;
  endfunction

  function automatic rsp_t mk(input int id, input logic [7:0] s, input logic c, input logic o);
    rsp_t r;
    r.id = ID_W'(id); r.s = s; r.cout = c; r.ovf = o;
    return r;
  endfunction

  function automatic logic [11:0] dut_rsp();
    return {bus.rsp_id, bus.rsp_s, bus.rsp_cout, bus.rsp_ovf};
  endfunction

  task automatic set_op(input int i, input logic [7:0] a, input logic [7:0] b, input logic ci);
    bus.req_a[i*ANCHO +: ANCHO] = a;
    bus.req_b[i*ANCHO +: ANCHO] = b;
    bus.req_ci[i]               = ci;
    bus.req_valid[i]            = 1'b1;
  endtask

  task automatic do_reset();
    rst_n         = 1'b0;
    bus.req_valid = '0;
    bus.req_a     = '0;
    bus.req_b     = '0;
    bus.req_ci    = '0;
    bus.rsp_ready = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    exp_q.delete();
  endtask

  // Offer one request, expect it to be the sole grant, push its result,
  // then withdraw and scramble the operands.
  task automatic do_req(input string name, input int i, input logic [7:0] a, input logic [7:0] b,
                        input logic ci, input rsp_t exp);
    bit got;
    got = 1'b0;
    @(posedge clk); #1;
    set_op(i, a, b, ci);
    for (int c = 0; c < 20 && !got; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        check({name, " grant"}, 32'(bus.req_ready), 32'(1 << i));
        if (bus.req_ready[i]) begin
          exp_q.push_back(exp);
          got = 1'b1;
        end
      end
    end
    if (!got) check({name, " grant timeout"}, 0, 1);
    @(posedge clk); #1;
    bus.req_valid[i]            = 1'b0;
    bus.req_a[i*ANCHO +: ANCHO] = ~a;
    bus.req_b[i*ANCHO +: ANCHO] = ~b;
    bus.req_ci[i]               = ~ci;
  endtask

  task automatic drain(input string name);
    for (int c = 0; c < 30 && exp_q.size() != 0; c++) @(negedge clk);
    check({name, " drained"}, 32'(exp_q.size()), 0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[7];
    int   k, last, w;

    vecs[0] = '{1, 8'hFF, 8'h01, 1'b1, mk(1, 8'h01, 1'b1, 1'b0)};
    vecs[1] = '{2, 8'h7F, 8'h01, 1'b0, mk(2, 8'h80, 1'b0, 1'b1)};
    vecs[2] = '{3, 8'h80, 8'h80, 1'b0, mk(3, 8'h00, 1'b1, 1'b1)};
    vecs[3] = '{0, 8'h7F, 8'h00, 1'b1, mk(0, 8'h80, 1'b0, 1'b1)};
    vecs[4] = '{1, 8'h00, 8'h00, 1'b0, mk(1, 8'h00, 1'b0, 1'b0)};
    vecs[5] = '{2, 8'hFF, 8'hFF, 1'b1, mk(2, 8'hFF, 1'b1, 1'b0)};
    vecs[6] = '{3, 8'h80, 8'hFF, 1'b0, mk(3, 8'h7F, 1'b1, 1'b1)};

    rst_n = 1'b0;

    // Scoreboard monitor: compare every accepted response, flag multi-grants.
    fork
      forever begin
        @(negedge clk);
        if (rst_n === 1'b1) begin
          check("req_ready onehot", 32'($countones(bus.req_ready) <= 1), 1);
          if (bus.rsp_valid && bus.rsp_ready) begin
            if (exp_q.size() == 0) check("unexpected rsp", 1, 0);
            else begin
              rsp_t e;
              e = exp_q.pop_front();
              check("rsp", 32'(dut_rsp()), 32'(e));
            end
          end
        end
      end
    join_none

    do_reset();
    @(negedge clk);
    check("reset busy", 32'(busy), 0);
    check("reset rsp_valid", 32'(bus.rsp_valid), 0);
    check("reset req_ready", 32'(bus.req_ready), 0);
    check("reset rsp fields", 32'(dut_rsp()), 0);

    // Single request: same-cycle ready, result two cycles after handshake.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    set_op(0, 8'h0A, 8'h05, 1'b0);
    @(negedge clk);
    check("t1 ready same cycle", 32'(bus.req_ready), 32'b0001);
    if (bus.req_ready[0]) exp_q.push_back(mk(0, 8'h0F, 1'b0, 1'b0));
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("t1 T+1 rsp_valid", 32'(bus.rsp_valid), 0);
    check("t1 T+1 busy", 32'(busy), 1);
    @(negedge clk);
    check("t1 T+2 rsp_valid", 32'(bus.rsp_valid), 1);
    drain("t1");

    // Vector table: carry, overflow and wrap cases one at a time.
    for (int v = 0; v < 7; v++) begin
      do_req($sformatf("vec%0d", v), vecs[v].req, vecs[v].a, vecs[v].b, vecs[v].ci, vecs[v].exp);
      drain($sformatf("vec%0d", v));
    end

    // All four requesting continuously from reset: order 0,1,2,3,0 every 3 cycles.
    do_reset();
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    for (int i = 0; i < NUM_REQ; i++)
      set_op(i, 8'(8'h17 * (i + 1)), 8'(8'hF0 - i), 1'(i));
    k = 0; last = 0;
    for (int cyc = 0; cyc < 40 && k < 5; cyc++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        w = 0;
        for (int i = 0; i < NUM_REQ; i++) if (bus.req_ready[i]) w = i;
        check($sformatf("rr order %0d", k), 32'(w), 32'(k % NUM_REQ));
        if (k > 0) check($sformatf("rr spacing %0d", k), 32'(cyc - last), 3);
        exp_q.push_back(model(w, bus.req_a[w*ANCHO +: ANCHO], bus.req_b[w*ANCHO +: ANCHO], bus.req_ci[w]));
        last = cyc;
        k++;
      end
    end
    check("rr grant count", 32'(k), 5);
    @(posedge clk); #1;
    bus.req_valid = '0;
    drain("rr");

    // Backpressure: result held for 5 cycles, then the pending req0 is taken.
    @(posedge clk); #1;
    bus.rsp_ready = 1'b0;
    do_req("bp", 2, 8'h12, 8'h34, 1'b1, mk(2, 8'h47, 1'b0, 1'b0));
    set_op(0, 8'h01, 8'h02, 1'b0);
    @(negedge clk);
    @(negedge clk);
    check("bp rsp_valid", 32'(bus.rsp_valid), 1);
    for (int c = 0; c < 5; c++) begin
      @(negedge clk);
      check($sformatf("bp hold %0d", c), 32'(dut_rsp()), 32'(mk(2, 8'h47, 1'b0, 1'b0)));
      check($sformatf("bp valid %0d", c), 32'(bus.rsp_valid), 1);
      check($sformatf("bp busy %0d", c), 32'(busy), 1);
      check($sformatf("bp req_ready %0d", c), 32'(bus.req_ready), 0);
    end
    @(posedge clk); #1;
    bus.rsp_ready = 1'b1;
    @(negedge clk);
    check("bp ready in RESP", 32'(bus.req_ready), 0);
    @(negedge clk);
    check("bp next grant", 32'(bus.req_ready), 32'b0001);
    check("bp idle busy", 32'(busy), 0);
    check("bp idle rsp_valid", 32'(bus.rsp_valid), 0);
    if (bus.req_ready[0]) exp_q.push_back(mk(0, 8'h03, 1'b0, 1'b0));
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    drain("bp");

    // Pointer fairness: after a grant to 2, req3 beats req0, then req0.
    do_req("fair2", 2, 8'h05, 8'h06, 1'b0, mk(2, 8'h0B, 1'b0, 1'b0));
    drain("fair2");
    @(posedge clk); #1;
    set_op(0, 8'h20, 8'h22, 1'b0);
    set_op(3, 8'h40, 8'h41, 1'b1);
    @(negedge clk);
    check("fair first", 32'(bus.req_ready), 32'b1000);
    if (bus.req_ready[3]) exp_q.push_back(mk(3, 8'h82, 1'b0, 1'b1));
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    k = 0;
    for (int c = 0; c < 10 && k == 0; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        check("fair second", 32'(bus.req_ready), 32'b0001);
        if (bus.req_ready[0]) exp_q.push_back(mk(0, 8'h42, 1'b0, 1'b0));
        k = 1;
      end
    end
    check("fair second seen", 32'(k), 1);
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    drain("fair");

    // Reset while in SUMA: drops at once, pointer restarts, nothing stale.
    do_req("rst", 1, 8'h11, 8'h22, 1'b0, mk(1, 8'h33, 1'b0, 1'b0));
    check("rst pre busy", 32'(busy), 1);
    rst_n = 1'b0;
    #1;
    check("rst async busy", 32'(busy), 0);
    check("rst async rsp_valid", 32'(bus.rsp_valid), 0);
    exp_q.delete();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    set_op(0, 8'h09, 8'h09, 1'b0);
    set_op(3, 8'h01, 8'hFE, 1'b0);
    @(negedge clk);
    check("rst first winner", 32'(bus.req_ready), 32'b0001);
    check("rst no stale 0", 32'(bus.rsp_valid), 0);
    if (bus.req_ready[0]) exp_q.push_back(mk(0, 8'h12, 1'b0, 1'b0));
    @(posedge clk); #1;
    bus.req_valid[0] = 1'b0;
    @(negedge clk);
    check("rst no stale 1", 32'(bus.rsp_valid), 0);
    k = 0;
    for (int c = 0; c < 10 && k == 0; c++) begin
      @(negedge clk);
      if (bus.req_ready != '0) begin
        check("rst second winner", 32'(bus.req_ready), 32'b1000);
        if (bus.req_ready[3]) exp_q.push_back(mk(3, 8'hFF, 1'b0, 1'b0));
        k = 1;
      end
    end
    check("rst second seen", 32'(k), 1);
    @(posedge clk); #1;
    bus.req_valid[3] = 1'b0;
    drain("rst");

    repeat (3) @(negedge clk);
    check("final queue empty", 32'(exp_q.size()), 0);
    check("final idle", 32'(busy), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
